// File: rtl/axi4lite_master.sv
// -----------------------------------------------------------------------------
// axi4lite_master
//
// AXI4-Lite initiator. A single read or write command taken from the local
// command port becomes one AXI4-Lite transaction. The BRESP/RRESP and read
// data come back on the local response port. Only one transaction is
// outstanding at a time.
//
// Optional feature macro: AXI4LITE_MASTER_TIMEOUT_EN
//   When defined, a saturating counter runs while the FSM waits on the bus.
//   A sticky timeout_err output is raised once the counter reaches
//   TIMEOUT_CYCLES. The transaction is never abandoned.
//
// Parameters
//   ADDR_WIDTH      address width (AW_ADDR, AR_ADDR, cmd_addr)
//   DATA_WIDTH      data width, 32 or 64; strobe width is DATA_WIDTH/8
//   TIMEOUT_CYCLES  timeout threshold (only used with the macro defined)
//
// Ports
//   A_CLK, A_RSTn          clock (rising edge), asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake
//   cmd_write              1 = write, 0 = read
//   cmd_addr/wdata/wstrb   command payload
//   rsp_valid/rsp_ready    response handshake
//   rsp_write              response belongs to a write
//   rsp_rdata, rsp_resp    read data (zero for writes), BRESP/RRESP
//   AW_*, W_*, B_*         AXI4-Lite write channels
//   AR_*, R_*              AXI4-Lite read channels
//   timeout_err            sticky timeout flag (macro only)
//
// Handshake semantics, every channel: a transfer happens on a rising edge
// where VALID and READY are both high. VALID never depends combinationally
// on READY. Once raised, VALID and its payload hold until the transfer.
// -----------------------------------------------------------------------------
module axi4lite_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      A_CLK,
    input  logic                      A_RSTn,

    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_write,
    input  logic [ADDR_WIDTH-1:0]     cmd_addr,
    input  logic [DATA_WIDTH-1:0]     cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0]   cmd_wstrb,

    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic [1:0]                rsp_resp,

    output logic                      AW_VALID,
    input  logic                      AW_READY,
    output logic [ADDR_WIDTH-1:0]     AW_ADDR,
    output logic [2:0]                AW_PROT,

    output logic                      W_VALID,
    input  logic                      W_READY,
    output logic [DATA_WIDTH-1:0]     W_DATA,
    output logic [DATA_WIDTH/8-1:0]   W_STRB,

    input  logic                      B_VALID,
    output logic                      B_READY,
    input  logic [1:0]                B_RESP,

    output logic                      AR_VALID,
    input  logic                      AR_READY,
    output logic [ADDR_WIDTH-1:0]     AR_ADDR,
    output logic [2:0]                AR_PROT,

    input  logic                      R_VALID,
    output logic                      R_READY,
    input  logic [DATA_WIDTH-1:0]     R_DATA,
    input  logic [1:0]                R_RESP
`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    ,
    output logic                      timeout_err
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;

    // Elaboration-time guard on the parameter ranges.
    if ((DATA_WIDTH != 32 && DATA_WIDTH != 64) || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("axi4lite_master: DATA_WIDTH must be 32 or 64 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_REQ  = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_REQ  = 3'd3,
        S_RD_RESP = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    // Per-channel completion flags for the write request phase. AW and W may
    // complete in either order or together.
    logic                    aw_done_q;
    logic                    w_done_q;

    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;

    logic                    rsp_write_q;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic [1:0]              rsp_resp_q;

    logic                    cmd_hs;
    logic                    aw_hs;
    logic                    w_hs;
    logic                    aw_finished;
    logic                    w_finished;

    assign cmd_hs      = cmd_valid && cmd_ready;
    assign aw_hs       = AW_VALID && AW_READY;
    assign w_hs        = W_VALID && W_READY;
    // A channel counts as finished if it completed earlier or completes now.
    assign aw_finished = aw_done_q || aw_hs;
    assign w_finished  = w_done_q || w_hs;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_hs) begin
                    state_d = cmd_write ? S_WR_REQ : S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                if (aw_finished && w_finished) begin
                    state_d = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (B_VALID) begin
                    state_d = S_RSP;
                end
            end
            S_RD_REQ: begin
                if (AR_READY) begin
                    state_d = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (R_VALID) begin
                    state_d = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM: outputs. All VALID/READY outputs are decoded from registered state
    // only, so none of them depends combinationally on a READY/VALID input.
    // -------------------------------------------------------------------------
    always_comb begin
        cmd_ready = 1'b0;
        AW_VALID  = 1'b0;
        W_VALID   = 1'b0;
        B_READY   = 1'b0;
        AR_VALID  = 1'b0;
        R_READY   = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            S_IDLE:    cmd_ready = 1'b1;
            S_WR_REQ: begin
                AW_VALID = !aw_done_q;
                W_VALID  = !w_done_q;
            end
            S_WR_RESP: B_READY   = 1'b1;
            S_RD_REQ:  AR_VALID  = 1'b1;
            S_RD_RESP: R_READY   = 1'b1;
            S_RSP:     rsp_valid = 1'b1;
            default:   cmd_ready = 1'b0;
        endcase
    end

    // Payloads come straight from the command latch, so they are stable for
    // the whole time VALID is high.
    assign AW_ADDR   = addr_q;
    assign AR_ADDR   = addr_q;
    assign AW_PROT   = 3'b000;
    assign AR_PROT   = 3'b000;
    assign W_DATA    = wdata_q;
    assign W_STRB    = wstrb_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

    // -------------------------------------------------------------------------
    // Write-phase completion flags. Cleared while idle so every write starts
    // with both channels pending.
    // -------------------------------------------------------------------------
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == S_IDLE) begin
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (state_q == S_WR_REQ) begin
            if (aw_hs) begin
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                w_done_q <= 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Command latch
    // -------------------------------------------------------------------------
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
        end else if (cmd_hs) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    // -------------------------------------------------------------------------
    // Response capture. Error codes are passed through untouched.
    // -------------------------------------------------------------------------
    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= 2'b00;
        end else if (state_q == S_WR_RESP && B_VALID) begin
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= B_RESP;
        end else if (state_q == S_RD_RESP && R_VALID) begin
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= R_DATA;
            rsp_resp_q  <= R_RESP;
        end
    end

`ifdef AXI4LITE_MASTER_TIMEOUT_EN
    // -------------------------------------------------------------------------
    // Bus-wait timeout. The counter runs only in the four bus states, holds
    // in RSP, clears in IDLE and saturates at the threshold.
    // -------------------------------------------------------------------------
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    logic [TO_W-1:0] to_cnt_q;
    logic            bus_wait;

    assign bus_wait = (state_q == S_WR_REQ) || (state_q == S_WR_RESP) ||
                      (state_q == S_RD_REQ) || (state_q == S_RD_RESP);

    always_ff @(posedge A_CLK or negedge A_RSTn) begin
        if (!A_RSTn) begin
            to_cnt_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (state_q == S_IDLE) begin
                to_cnt_q <= '0;
            end else if (bus_wait && to_cnt_q != TO_MAX) begin
                to_cnt_q <= to_cnt_q + 1'b1;
            end
            if (to_cnt_q == TO_MAX) begin
                timeout_err <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: doc/axi4lite_master.md
# axi4lite_master

AXI4-Lite master (initiator) that turns single read/write commands from a local command port into AXI4-Lite transactions and returns the response on a local response port. It is the initiator end of the bus served by the team's AXI4-Lite slave, and it drives that slave in the integration bench and in register-access paths. One transaction is outstanding at a time.

## Interface

Parameters:
- ADDR_WIDTH, 32, width of AW_ADDR, AR_ADDR and cmd_addr.
- DATA_WIDTH, 32, width of the data buses. Legal values are 32 and 64. Strobe width is DATA_WIDTH/8.
- TIMEOUT_CYCLES, 256, response timeout threshold. Used only with AXI4LITE_MASTER_TIMEOUT_EN.

Ports:
- A_CLK  in  1  clock. Everything is synchronous to its rising edge.
- A_RSTn  in  1  reset. Asynchronous assert, active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_write  out  1  response belongs to a write.
- rsp_rdata  out  DATA_WIDTH  read data. Zero for writes.
- rsp_resp  out  2  BRESP or RRESP of the transaction.
- AW_VALID, AW_READY, AW_ADDR, AW_PROT (out/in/out/out, 1/1/ADDR_WIDTH/3): write address channel.
- W_VALID, W_READY, W_DATA, W_STRB (out/in/out/out, 1/1/DATA_WIDTH/DATA_WIDTH/8): write data channel.
- B_VALID, B_READY, B_RESP (in/out/in, 1/1/2): write response channel.
- AR_VALID, AR_READY, AR_ADDR, AR_PROT (out/in/out/out, 1/1/ADDR_WIDTH/3): read address channel.
- R_VALID, R_READY, R_DATA, R_RESP (in/out/in/in, 1/1/DATA_WIDTH/2): read data channel.
- timeout_err  out  1  sticky timeout flag. Present only with AXI4LITE_MASTER_TIMEOUT_EN.

## Operation

- FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready, latch the command and go to WR_REQ if cmd_write, else RD_REQ.
- WR_REQ:
  - AW_VALID and W_VALID are both registered high on entry.
  - Each channel drops the cycle after its own handshake. The two handshakes may occur in either order or in the same cycle; per-channel done flags track them.
  - Go to WR_RESP once both are done.
- WR_RESP:
  - B_READY = 1.
  - On B_VALID, capture B_RESP, set rsp_write = 1 and rsp_rdata = 0, then go to RSP.
- RD_REQ:
  - AR_VALID is high.
  - On AR_READY, go to RD_RESP.
- RD_RESP:
  - R_READY = 1.
  - On R_VALID, capture R_DATA and R_RESP, set rsp_write = 0, then go to RSP.
- RSP:
  - rsp_valid = 1, with rsp_* held stable.
  - On rsp_ready, go to IDLE.
- Channel rules:
  - No VALID ever depends combinationally on the matching READY.
  - Once VALID is asserted, it and its payload stay stable until the handshake.
  - AW_PROT = AR_PROT = 3'b000.
  - B_READY and R_READY are low outside WR_RESP and RD_RESP. B_VALID and R_VALID arriving outside those states are ignored.
- Error responses (SLVERR = 2'b10, DECERR = 2'b11) are passed through unchanged. They are not retried.

## Timing

- Reset values:
  - All AXI VALID and READY outputs are 0.
  - Addresses, data, strobes and PROT are 0.
  - cmd_ready = 1 (state IDLE).
  - rsp_valid = 0, rsp_write = 0, rsp_rdata = 0, rsp_resp = 0.
  - timeout_err = 0.
- Reset mid-transaction: outputs return to their reset values immediately (asynchronous), and the in-flight command is dropped.
- Write with a zero-wait slave:
  - Command accepted at edge 0.
  - AW_VALID and W_VALID high in cycle 1. Handshake at edge 1.
  - B_READY high in cycle 2. With B_VALID present, handshake at edge 2.
  - rsp_valid high in cycle 3.
  - With rsp_ready = 1, cmd_ready returns high in cycle 4.
- Read with a zero-wait slave: identical timeline on the AR/R channels.
- Minimum command spacing is therefore 4 cycles. Slave wait states add 1:1 to the timeline.
- cmd_ready is low from the cycle after acceptance until the cycle after the rsp handshake.

## Configuration

- Macro: AXI4LITE_MASTER_TIMEOUT_EN.
- Defined:
  - A counter runs in WR_REQ, WR_RESP, RD_REQ and RD_RESP. It clears on entry to IDLE.
  - When the counter reaches TIMEOUT_CYCLES, timeout_err is set and stays set until reset.
  - The transaction is not abandoned: the FSM keeps waiting, so protocol correctness is preserved.
  - The counter saturates and does not wrap.
- Undefined: no counter, no timeout_err port, and the FSM behaves identically otherwise.

## Test plan

- Write, zero-wait slave: cmd addr 0x10, wdata 0xDEADBEEF, wstrb 0xF. Required: AW/W handshake at edge 1 with exactly those values, rsp_valid in cycle 3, rsp_resp 2'b00, rsp_write 1, cmd_ready back in cycle 4.
- Write with skewed readies: W_READY delayed 3 cycles after AW_READY. Required: AW_VALID drops after its handshake, W_VALID holds 0xA5A5A5A5 stable until its handshake, and B_READY is not asserted before the W handshake.
- Read, slave returns 0x12345678 with SLVERR after 2 wait cycles. Required: rsp_rdata 0x12345678, rsp_resp 2'b10, rsp_write 0, AR_ADDR stable throughout.
- Response backpressure: rsp_ready held low 5 cycles. Required: rsp_* held stable, cmd_ready stays 0, and a new cmd_valid is not accepted.
- Reset asserted while AW_VALID is high. Required: all outputs go to reset values without waiting for a clock edge, and cmd_ready = 1 after release.
- With AXI4LITE_MASTER_TIMEOUT_EN and TIMEOUT_CYCLES = 8: B_VALID withheld 20 cycles. Required: timeout_err rises after 8 cycles in the wait states and stays high after B arrives and the response completes normally.
